// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: picks LFSR-driven mole positions, times each round,
// judges submitted guesses and tracks score and misses for the LED display stage.
module mole_game_ctrl #(
    parameter int unsigned ROUND_TICKS = 10000,
    parameter int unsigned MAX_MISSES  = 3,
    parameter int unsigned SCORE_W     = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_restart,
    input  logic [2:0]         i_guess_sw,
    input  logic               i_submit,
    output logic [2:0]         o_user_guess,
    output logic [2:0]         o_mole_position,
    output logic               o_user_right,
    output logic               o_user_wrong,
    output logic               o_game_over,
    output logic               o_restart_game,
    output logic [SCORE_W-1:0] o_score,
    output logic [1:0]         o_misses
);

    localparam int unsigned      CNT_W      = (ROUND_TICKS > 1) ? $clog2(ROUND_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(ROUND_TICKS - 1);
    localparam logic [1:0]       MISS_LIMIT = 2'(MAX_MISSES);

    typedef enum logic [1:0] {StNewMole, StWaitGuess, StGameOver} state_e;

    state_e           state_q;
    logic [15:0]      lfsr_q;
    logic             lfsr_fb;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       cand;
    logic             guess_hit;
    logic [1:0]       misses_inc;

    always_comb begin
        // Fibonacci taps 16,14,13,11 in right-shift form
        lfsr_fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        cand       = lfsr_q[2:0];
        if (cand == o_mole_position) begin
            cand = cand + 3'd1;
        end
        guess_hit  = (o_user_guess == o_mole_position);
        misses_inc = o_misses + 2'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= StNewMole;
            lfsr_q          <= LFSR_SEED;
            cnt_q           <= '0;
            o_user_guess    <= '0;
            o_mole_position <= '0;
            o_user_right    <= 1'b0;
            o_user_wrong    <= 1'b0;
            o_game_over     <= 1'b0;
            o_restart_game  <= 1'b0;
            o_score         <= '0;
            o_misses        <= '0;
        end else begin
            lfsr_q         <= {lfsr_fb, lfsr_q[15:1]};
            o_user_guess   <= i_guess_sw;
            o_user_right   <= 1'b0;
            o_user_wrong   <= 1'b0;
            o_restart_game <= 1'b0;

            if (i_restart) begin
                state_q        <= StNewMole;
                cnt_q          <= '0;
                o_score        <= '0;
                o_misses       <= '0;
                o_game_over    <= 1'b0;
                o_restart_game <= 1'b1;
            end else begin
                unique case (state_q)
                    StNewMole: begin
                        o_mole_position <= cand;
                        cnt_q           <= CNT_LOAD;
                        state_q         <= StWaitGuess;
                    end
                    StWaitGuess: begin
                        if (i_submit && guess_hit) begin
                            o_user_right <= 1'b1;
                            if (o_score != {SCORE_W{1'b1}}) begin
                                o_score <= o_score + SCORE_W'(1);
                            end
                            state_q <= StNewMole;
                        end else if (i_submit || (cnt_q == '0)) begin
                            // a submit on the final tick is judged; the timeout is dropped
                            o_user_wrong <= 1'b1;
                            o_misses     <= misses_inc;
                            if (misses_inc == MISS_LIMIT) begin
                                o_game_over <= 1'b1;
                                state_q     <= StGameOver;
                            end else begin
                                state_q <= StNewMole;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    StGameOver: begin
                        state_q <= StGameOver;
                    end
                    default: begin
                        state_q <= StNewMole;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: scoreboard of expected pulse events, a table of play vectors,
// and hand sequences for timeout timing, game-over, restart and position-collision corners.
module tb_mole_game_ctrl;

    localparam int unsigned TICKS = 16;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       restart = 1'b0;
    logic       submit  = 1'b0;
    logic [2:0] guess   = 3'd0;
    logic [2:0] user_guess, mole_pos;
    logic       user_right, user_wrong, game_over, restart_game;
    logic [7:0] score;
    logic [1:0] misses;

    logic       rst2_n = 1'b0;
    logic       restart2 = 1'b0;
    logic       s2 = 1'b0;
    logic [2:0] g2 = 3'd0;
    logic [2:0] ug2, pos2;
    logic       right2, wrong2, go2, rgame2;
    logic [7:0] score2;
    logic [1:0] misses2;

    always #5 clk = ~clk;

    mole_game_ctrl #(
        .ROUND_TICKS(TICKS), .MAX_MISSES(3), .SCORE_W(8), .LFSR_SEED(16'hACE1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart), .i_guess_sw(guess),
        .i_submit(submit), .o_user_guess(user_guess), .o_mole_position(mole_pos),
        .o_user_right(user_right), .o_user_wrong(user_wrong), .o_game_over(game_over),
        .o_restart_game(restart_game), .o_score(score), .o_misses(misses)
    );

    // Long rounds and a seed with low bits 000 for the collision corners
    mole_game_ctrl #(
        .ROUND_TICKS(1024), .MAX_MISSES(3), .SCORE_W(8), .LFSR_SEED(16'hACE0)
    ) dut2 (
        .i_clk(clk), .i_rst_n(rst2_n), .i_restart(restart2), .i_guess_sw(g2),
        .i_submit(s2), .o_user_guess(ug2), .o_mole_position(pos2),
        .o_user_right(right2), .o_user_wrong(wrong2), .o_game_over(go2),
        .o_restart_game(rgame2), .o_score(score2), .o_misses(misses2)
    );

    typedef struct packed {
        logic       r;
        logic       w;
        logic       g;
        logic [7:0] score;
        logic [1:0] mis;
        logic       go;
    } exp_t;

    typedef struct packed {
        logic [2:0] off;
        logic       sub;
        logic       rst;
        exp_t       ev;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        e;
    vec_t        vecs[11];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc, last_pulse_cyc;
    logic [15:0] m_lfsr, m2_lfsr, nl;
    logic [2:0]  mpos, prev, expos;
    bit          found;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic [15:0] b;
        b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h0001;
        return (l >> 1) | (b << 15);
    endfunction

    function automatic logic [2:0] pick(input logic [15:0] l, input logic [2:0] cur);
        logic [2:0] c;
        c = l[2:0];
        if (c == cur) c = c + 3'd1;
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
            cyc    <= 0;
        end else begin
            m_lfsr <= lfsr_step(m_lfsr);
            cyc    <= cyc + 1;
        end
    end

    always @(posedge clk or negedge rst2_n) begin
        if (!rst2_n) m2_lfsr <= 16'hACE0;
        else         m2_lfsr <= lfsr_step(m2_lfsr);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic seek7();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            nl = lfsr_step(m2_lfsr);
            if (nl[2:0] == 3'd7) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("lfsr_seek", 32'(found), 32'd1);
    endtask

    initial begin
        //            off   sub   rst    r     w     g     score  mis   go
        vecs[0]  = '{3'd0, 1'b1, 1'b0, '{1'b1, 1'b0, 1'b0, 8'd1, 2'd0, 1'b0}};
        vecs[1]  = '{3'd1, 1'b1, 1'b0, '{1'b0, 1'b1, 1'b0, 8'd1, 2'd1, 1'b0}};
        vecs[2]  = '{3'd0, 1'b1, 1'b0, '{1'b1, 1'b0, 1'b0, 8'd2, 2'd1, 1'b0}};
        vecs[3]  = '{3'd0, 1'b1, 1'b0, '{1'b1, 1'b0, 1'b0, 8'd3, 2'd1, 1'b0}};
        vecs[4]  = '{3'd3, 1'b1, 1'b0, '{1'b0, 1'b1, 1'b0, 8'd3, 2'd2, 1'b0}};
        vecs[5]  = '{3'd0, 1'b0, 1'b1, '{1'b0, 1'b0, 1'b1, 8'd0, 2'd0, 1'b0}};
        vecs[6]  = '{3'd0, 1'b1, 1'b0, '{1'b1, 1'b0, 1'b0, 8'd1, 2'd0, 1'b0}};
        vecs[7]  = '{3'd0, 1'b1, 1'b1, '{1'b0, 1'b0, 1'b1, 8'd0, 2'd0, 1'b0}};
        vecs[8]  = '{3'd5, 1'b1, 1'b0, '{1'b0, 1'b1, 1'b0, 8'd0, 2'd1, 1'b0}};
        vecs[9]  = '{3'd1, 1'b1, 1'b0, '{1'b0, 1'b1, 1'b0, 8'd0, 2'd2, 1'b0}};
        vecs[10] = '{3'd2, 1'b1, 1'b0, '{1'b0, 1'b1, 1'b0, 8'd0, 2'd3, 1'b1}};

        // Every pulse must match the oldest outstanding expectation
        fork
            forever begin
                @(negedge clk);
                if (rst_n && (user_right || user_wrong || restart_game)) begin
                    last_pulse_cyc = cyc;
                    chk("pulse_onehot", 32'($countones({user_right, user_wrong, restart_game})),
                        32'd1);
                    chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("sb_event", 32'({user_right, user_wrong, restart_game, score, misses,
                                             game_over}), 32'(e));
                    end
                end
            end
        join_none

        repeat (3) tick();
        chk("reset_state", 32'({user_guess, mole_pos, user_right, user_wrong, game_over,
                                restart_game, score, misses}), 32'd0);
        rst_n = 1'b1;
        mpos  = 3'd0;

        // Idle play: three timeouts 17 cycles apart end the game
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back('{1'b0, 1'b1, 1'b0, 8'd0, 2'(k), 1'(k == 3)});
            expos = pick(m_lfsr, mpos);
            tick();
            chk("mole_after_idle", 32'(mole_pos), 32'(expos));
            mpos = expos;
            wait_drain(40);
            chk("timeout_cycle", last_pulse_cyc, 32'(17 * k));
        end

        // Submit in game-over is ignored
        guess  = mpos;
        submit = 1'b1;
        tick();
        submit = 1'b0;
        repeat (4) tick();
        chk("game_over_hold", 32'({score, misses, game_over, mole_pos}),
            32'({8'd0, 2'd3, 1'b1, mpos}));

        // Restart beats a same-cycle submit
        restart = 1'b1;
        submit  = 1'b1;
        exp_q.push_back('{1'b0, 1'b0, 1'b1, 8'd0, 2'd0, 1'b0});
        tick();
        restart = 1'b0;
        submit  = 1'b0;
        wait_drain(8);

        for (int i = 0; i < 11; i++) begin
            prev  = mpos;
            expos = pick(m_lfsr, mpos);
            tick();
            chk("new_mole", 32'(mole_pos), 32'(expos));
            chk("mole_moved", 32'(mole_pos != prev), 32'd1);
            mpos  = expos;
            guess = mpos + vecs[i].off;
            tick();
            chk("guess_reg", 32'(user_guess), 32'(guess));
            submit  = vecs[i].sub;
            restart = vecs[i].rst;
            exp_q.push_back(vecs[i].ev);
            tick();
            submit  = 1'b0;
            restart = 1'b0;
            wait_drain(8);
        end

        repeat (3) tick();
        chk("over_mole_held", 32'({game_over, mole_pos}), 32'({1'b1, mpos}));

        restart = 1'b1;
        exp_q.push_back('{1'b0, 1'b0, 1'b1, 8'd0, 2'd0, 1'b0});
        tick();
        restart = 1'b0;
        wait_drain(8);

        // Correct submit on the final tick wins over the timeout
        expos = pick(m_lfsr, mpos);
        tick();
        chk("new_mole_t5", 32'(mole_pos), 32'(expos));
        mpos  = expos;
        guess = mpos;
        repeat (15) tick();
        submit = 1'b1;
        exp_q.push_back('{1'b1, 1'b0, 1'b0, 8'd1, 2'd0, 1'b0});
        tick();
        submit = 1'b0;
        wait_drain(8);

        // Asynchronous reset mid-round
        expos = pick(m_lfsr, mpos);
        tick();
        chk("new_mole_pre_rst", 32'(mole_pos), 32'(expos));
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({user_guess, mole_pos, user_right, user_wrong, game_over,
                                restart_game, score, misses}), 32'd0);

        // Collision corners on the second instance
        tick();
        rst2_n = 1'b1;
        tick();
        chk("collision_bump", 32'(pos2), 32'd1);
        g2 = 3'd1;
        tick();
        seek7();
        s2 = 1'b1;
        tick();
        s2 = 1'b0;
        chk("d2_right_a", 32'(right2), 32'd1);
        tick();
        chk("reach_7", 32'(pos2), 32'd7);
        g2 = 3'd7;
        tick();
        chk("d2_guess_reg", 32'(ug2), 32'd7);
        seek7();
        s2 = 1'b1;
        tick();
        s2 = 1'b0;
        chk("d2_right_b", 32'(right2), 32'd1);
        tick();
        chk("wrap_7_to_0", 32'(pos2), 32'd0);
        chk("d2_status", 32'({score2, misses2, wrong2, go2, rgame2}), 32'({8'd2, 5'd0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
